// File: rtl/vlsu_bank_scheduler_if.sv
// ---------------------------------------------------------------------------
// vlsu_bank_scheduler_if
// Groups the request, issue and acknowledge signals of the VLSU bank
// scheduler.
//   slave  : the scheduler side (takes the request, drives the issue outputs)
//   master : the environment side (vector unit request port plus bank array)
// Signals:
//   req_i/lane_valid_i/lane_we_i/lane_addr_i : multi-lane request, lane i
//                                              address at [i*64+:64]
//   ready_o/done_o/busy_o                    : request handshake and status
//   issue_valid_o/issue_mask_o/issue_we_o    : conflict-free lane set offered
//                                              to the banks
//   issue_ready_i                            : banks take the whole set
//   lane_ack_i                               : per-lane completion
// ---------------------------------------------------------------------------
interface vlsu_bank_scheduler_if #(
    parameter int NUM_LANES = 8
);
    logic                      req_i;
    logic [NUM_LANES-1:0]      lane_valid_i;
    logic [NUM_LANES-1:0]      lane_we_i;
    logic [NUM_LANES*64-1:0]   lane_addr_i;
    logic                      ready_o;
    logic                      done_o;
    logic                      issue_valid_o;
    logic [NUM_LANES-1:0]      issue_mask_o;
    logic [NUM_LANES-1:0]      issue_we_o;
    logic                      issue_ready_i;
    logic [NUM_LANES-1:0]      lane_ack_i;
    logic                      busy_o;

    modport slave (
        input  req_i, lane_valid_i, lane_we_i, lane_addr_i,
        input  issue_ready_i, lane_ack_i,
        output ready_o, done_o, issue_valid_o, issue_mask_o, issue_we_o, busy_o
    );

    modport master (
        output req_i, lane_valid_i, lane_we_i, lane_addr_i,
        output issue_ready_i, lane_ack_i,
        input  ready_o, done_o, issue_valid_o, issue_mask_o, issue_we_o, busy_o
    );
endinterface

// File: rtl/vlsu_bank_scheduler.sv
// ---------------------------------------------------------------------------
// vlsu_bank_scheduler
// Takes one multi-lane VLSU request, then each cycle offers a bank-conflict-
// free subset of the remaining lanes to the word-interleaved dcache banks.
// Tracks issued-but-unacknowledged lanes and pulses done_o once every valid
// lane of the request has been acknowledged.
// Ports:
//   clk_i : clock
//   rst_i : synchronous active-high reset (drops any in-flight request)
//   bus   : vlsu_bank_scheduler_if.slave (request, issue and ack signals)
// ---------------------------------------------------------------------------
module vlsu_bank_scheduler #(
    parameter int NUM_LANES = 8,
    parameter int NUM_BANKS = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    vlsu_bank_scheduler_if.slave    bus
);
    localparam int BANK_W = $clog2(NUM_BANKS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                          state_r, state_s;
    logic [NUM_LANES-1:0]            pend_r, pend_s;
    logic [NUM_LANES-1:0]            outst_r, outst_s;
    logic [NUM_LANES-1:0]            we_r, we_s;
    logic [NUM_LANES-1:0][63:0]      addr_r, addr_s;
    logic                            done_r, done_s;

    logic [NUM_LANES-1:0][BANK_W-1:0] bank_s;
    logic [NUM_LANES-1:0]            blocked_s;
    logic [NUM_LANES-1:0]            grant_s;
    logic [NUM_LANES-1:0]            mask_s;
    logic [NUM_LANES-1:0]            outst_acked_s;
    logic                            unused_addr_s;

    // Only the bank-select bits of the latched addresses steer the schedule.
    assign unused_addr_s = ^addr_r;

    // Bank index per lane from the latched address (8-byte word interleave).
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            bank_s[i] = addr_r[i][3 +: BANK_W];
        end
    end

    // A pending lane is granted unless a lower-index pending lane targets the
    // same bank; this yields exactly the lowest pending lane per bank.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            blocked_s[i] = 1'b0;
            for (int j = 0; j < i; j++) begin
                blocked_s[i] = blocked_s[i] | (pend_r[j] & (bank_s[j] == bank_s[i]));
            end
            grant_s[i] = pend_r[i] & ~blocked_s[i];
        end
    end

    // Issue mask is only offered while issuing.
    assign mask_s = (state_r == ISSUE) ? grant_s : {NUM_LANES{1'b0}};

    // Acks only clear lanes already recorded as outstanding.
    assign outst_acked_s = outst_r & ~bus.lane_ack_i;

    // Next-state and register-update logic of the request sequencer.
    always_comb begin
        state_s = state_r;
        pend_s  = pend_r;
        outst_s = outst_r;
        we_s    = we_r;
        addr_s  = addr_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_i) begin
                    if (bus.lane_valid_i != {NUM_LANES{1'b0}}) begin
                        addr_s  = bus.lane_addr_i;
                        we_s    = bus.lane_we_i;
                        pend_s  = bus.lane_valid_i;
                        state_s = ISSUE;
                    end else begin
                        // Empty request completes immediately.
                        done_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (bus.issue_ready_i) begin
                    pend_s  = pend_r & ~mask_s;
                    outst_s = outst_acked_s | mask_s;
                    if (pend_s == {NUM_LANES{1'b0}}) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = ISSUE;
                    end
                end else begin
                    outst_s = outst_acked_s;
                end
            end
            DRAIN: begin
                outst_s = outst_acked_s;
                if (outst_s == {NUM_LANES{1'b0}}) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
                pend_s  = {NUM_LANES{1'b0}};
                outst_s = {NUM_LANES{1'b0}};
            end
        endcase
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            pend_r  <= {NUM_LANES{1'b0}};
            outst_r <= {NUM_LANES{1'b0}};
            we_r    <= {NUM_LANES{1'b0}};
            addr_r  <= '0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            pend_r  <= pend_s;
            outst_r <= outst_s;
            we_r    <= we_s;
            addr_r  <= addr_s;
            done_r  <= done_s;
        end
    end

    assign bus.ready_o       = (state_r == IDLE);
    assign bus.busy_o        = (state_r != IDLE);
    assign bus.done_o        = done_r;
    assign bus.issue_mask_o  = mask_s;
    assign bus.issue_valid_o = (mask_s != {NUM_LANES{1'b0}});
    assign bus.issue_we_o    = we_r & mask_s;
endmodule

// File: tb/tb_vlsu_bank_scheduler.sv
// ---------------------------------------------------------------------------
// tb_vlsu_bank_scheduler
// Scoreboard bench: the stimulus side predicts the issue-mask sequence of
// each request from the lowest-lane-per-bank rule and the done_o cycle from
// its own ack schedule; a forked monitor compares DUT outputs on the falling
// edge. Stimulus is driven 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_vlsu_bank_scheduler;
    localparam int NL = 8;
    localparam int NB = 8;

    typedef struct {
        logic [NL-1:0] mask;
        logic [NL-1:0] we;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;

    vlsu_bank_scheduler_if #(.NUM_LANES(NL)) bif ();

    vlsu_bank_scheduler #(.NUM_LANES(NL), .NUM_BANKS(NB)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    int            n_checks = 0;
    int            n_fail   = 0;
    exp_t          exp_q[$];
    int            done_q[$];
    int            ack_due[NL];
    int            lanes_left = 0;
    int            acc_cyc = 0;
    int            rdy_pct = 100;
    int            ack_min = 1;
    int            ack_max = 1;
    bit            auto_ack = 1'b1;
    bit            stray_en = 1'b0;
    logic [NL-1:0] force_ack = '0;
    bit            req_pending = 1'b0;
    logic [NL-1:0] req_valid = '0;
    logic [NL-1:0] req_we = '0;
    logic [NL*64-1:0] req_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: repeatedly give each bank its lowest remaining lane.
    function automatic void push_model(input logic [NL-1:0] valid, input logic [NL-1:0] we,
                                       input logic [NL*64-1:0] addr);
        logic [NL-1:0] pend;
        logic [NB-1:0] used;
        exp_t e;
        int bank;
        pend = valid;
        while (pend != '0) begin
            used = '0;
            e.mask = '0;
            for (int l = 0; l < NL; l++) begin
                bank = int'(addr[l*64+3 +: 3]);
                if (pend[l] && !used[bank]) begin
                    e.mask[l] = 1'b1;
                    used[bank] = 1'b1;
                end
            end
            e.we = we & e.mask;
            exp_q.push_back(e);
            pend = pend & ~e.mask;
        end
    endfunction

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bif.issue_valid_o) begin
                    if (exp_q.size() == 0) begin
                        check("issue_unexpected", {56'd0, bif.issue_mask_o}, 64'd0);
                    end else begin
                        check("issue_mask", {56'd0, bif.issue_mask_o}, {56'd0, exp_q[0].mask});
                        check("issue_we", {56'd0, bif.issue_we_o}, {56'd0, exp_q[0].we});
                        if (bif.issue_ready_i) void'(exp_q.pop_front());
                    end
                end
                if (bif.done_o) begin
                    if (done_q.size() == 0) begin
                        check("done_unexpected", 64'd1, 64'd0);
                    end else begin
                        check("done_cycle", 64'(cyc), 64'(done_q[0]));
                        check("ready_in_done", {63'd0, bif.ready_o}, 64'd1);
                        void'(done_q.pop_front());
                    end
                end else if (done_q.size() != 0 && done_q[0] <= cyc) begin
                    check("done_missing", 64'd0, 64'd1);
                    void'(done_q.pop_front());
                end
                check("busy_vs_ready", {63'd0, bif.busy_o}, {63'd0, ~bif.ready_o});
            end
        end
    endtask

    // One cycle of bank-side responses and request driving, then advance.
    task automatic step();
        logic [NL-1:0] ack, outst, stray;
        logic rdy;
        int c;
        c = cyc;
        rdy = ($urandom_range(0, 99) < rdy_pct);
        ack = '0;
        outst = '0;
        for (int l = 0; l < NL; l++) begin
            if (ack_due[l] == c) begin
                ack[l] = 1'b1;
                ack_due[l] = -1;
            end else if (ack_due[l] > c) begin
                outst[l] = 1'b1;
            end
        end
        if (ack != '0) begin
            lanes_left -= $countones(ack);
            if (lanes_left == 0) done_q.push_back(c + 1);
        end
        if (stray_en && $urandom_range(0, 3) == 0) begin
            stray = NL'($urandom()) & ~outst & ~ack;
            ack = ack | stray;
        end
        ack = ack | force_ack;
        bif.issue_ready_i = rdy;
        bif.lane_ack_i    = ack;
        if (auto_ack && bif.issue_valid_o && rdy) begin
            for (int l = 0; l < NL; l++) begin
                if (bif.issue_mask_o[l]) ack_due[l] = c + $urandom_range(ack_min, ack_max);
            end
        end
        bif.req_i        = req_pending;
        bif.lane_valid_i = req_valid;
        bif.lane_we_i    = req_we;
        bif.lane_addr_i  = req_addr;
        if (req_pending && bif.ready_o) begin
            push_model(req_valid, req_we, req_addr);
            lanes_left = $countones(req_valid);
            if (req_valid == '0) done_q.push_back(c + 1);
            acc_cyc = c;
            req_pending = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NL-1:0] valid, input logic [NL-1:0] we,
                        input logic [NL*64-1:0] addr);
        int n;
        req_valid = valid;
        req_we = we;
        req_addr = addr;
        req_pending = 1'b1;
        n = 0;
        while (req_pending && n < 100) begin
            step();
            n++;
        end
        if (req_pending) begin
            check("accept_timeout", 64'd0, 64'd1);
            req_pending = 1'b0;
        end
        bif.req_i = 1'b0;
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0 || lanes_left != 0) && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) begin
            check("quiet_timeout", 64'd0, 64'd1);
            exp_q.delete();
            done_q.delete();
            lanes_left = 0;
        end
    endtask

    function automatic logic [NL*64-1:0] addrs_from_banks(input int stride, input int base);
        logic [NL*64-1:0] a;
        for (int l = 0; l < NL; l++) a[l*64 +: 64] = 64'(base + stride * l);
        return a;
    endfunction

    initial begin
        logic [NL*64-1:0] a;
        int acc1, done_cyc;
        for (int l = 0; l < NL; l++) ack_due[l] = -1;
        rst = 1'b1;
        bif.req_i = 1'b0;
        bif.lane_valid_i = '0;
        bif.lane_we_i = '0;
        bif.lane_addr_i = '0;
        bif.issue_ready_i = 1'b0;
        bif.lane_ack_i = '0;
        fork
            monitor_loop();
        join_none
        @(posedge clk);
        #1;
        step();
        check("rst_ready", {63'd0, bif.ready_o}, 64'd1);
        check("rst_done", {63'd0, bif.done_o}, 64'd0);
        check("rst_issue_valid", {63'd0, bif.issue_valid_o}, 64'd0);
        check("rst_issue_mask", {56'd0, bif.issue_mask_o}, 64'd0);
        check("rst_issue_we", {56'd0, bif.issue_we_o}, 64'd0);
        check("rst_busy", {63'd0, bif.busy_o}, 64'd0);
        rst = 1'b0;
        step();

        // Distinct banks: single issue, done three cycles after accept.
        rdy_pct = 100; ack_min = 1; ack_max = 1;
        send(8'hFF, 8'hA5, addrs_from_banks(8, 32'h1000));
        done_cyc = -1;
        for (int k = 0; k < 10; k++) begin
            if (bif.done_o) begin
                done_cyc = cyc;
                break;
            end
            step();
        end
        check("distinct_latency", 64'(done_cyc), 64'(acc_cyc + 3));
        check("distinct_ready_after", {63'd0, bif.ready_o}, 64'd1);
        wait_quiet();

        // Full conflict, then partial conflict, with random ack delays.
        ack_max = 3;
        send(8'hFF, 8'h0F, addrs_from_banks(64, 32'h1000));
        wait_quiet();
        a = addrs_from_banks(8, 32'h1000);
        a[0*64 +: 64] = 64'h1010;
        a[1*64 +: 64] = 64'h1050;
        a[2*64 +: 64] = 64'h1000;
        a[3*64 +: 64] = 64'h1008;
        a[4*64 +: 64] = 64'h1018;
        a[5*64 +: 64] = 64'h1020;
        a[6*64 +: 64] = 64'h1028;
        a[7*64 +: 64] = 64'h1030;
        send(8'hFF, 8'h3C, a);
        wait_quiet();

        // Backpressure with stray acks on unissued lanes.
        rdy_pct = 0; stray_en = 1'b1;
        send(8'h0F, 8'h05, addrs_from_banks(8, 32'h2000));
        for (int k = 0; k < 4; k++) begin
            check("bp_mask", {56'd0, bif.issue_mask_o}, 64'h0F);
            check("bp_no_done", {63'd0, bif.done_o}, 64'd0);
            step();
        end
        rdy_pct = 100;
        wait_quiet();

        // Empty request, then a request accepted in the done cycle.
        send(8'h00, 8'h00, addrs_from_banks(8, 32'h3000));
        acc1 = acc_cyc;
        send(8'hF0, 8'hFF, addrs_from_banks(8, 32'h3000));
        check("b2b_accept_cycle", 64'(acc_cyc), 64'(acc1 + 1));
        wait_quiet();

        // Randomized requests with backpressure, stray acks and conflicts.
        rdy_pct = 70; ack_min = 1; ack_max = 3;
        for (int r = 0; r < 40; r++) begin
            logic [NL-1:0] v;
            v = ($urandom_range(0, 9) == 0) ? '0 : NL'($urandom());
            for (int l = 0; l < NL; l++) begin
                a[l*64 +: 64] = {$urandom(), $urandom()};
                a[l*64+3 +: 3] = 3'($urandom_range(0, 4));
            end
            send(v, NL'($urandom()), a);
        end
        rdy_pct = 100;
        wait_quiet();

        // Reset while draining with lanes 2,3 outstanding; late ack ignored.
        auto_ack = 1'b0; stray_en = 1'b0;
        send(8'h0C, 8'h04, addrs_from_banks(8, 32'h4000));
        step();
        check("drain_busy", {63'd0, bif.busy_o}, 64'd1);
        check("drain_issue_valid", {63'd0, bif.issue_valid_o}, 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_ready", {63'd0, bif.ready_o}, 64'd1);
        check("midrst_busy", {63'd0, bif.busy_o}, 64'd0);
        check("midrst_done", {63'd0, bif.done_o}, 64'd0);
        lanes_left = 0;
        exp_q.delete();
        done_q.delete();
        force_ack = 8'h0C;
        step();
        force_ack = '0;
        for (int k = 0; k < 5; k++) begin
            check("late_ack_no_done", {63'd0, bif.done_o}, 64'd0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vlsu_bank_scheduler.md
Name: vlsu_bank_scheduler

Overview:
Sequences one multi-lane VLSU request from the vector unit into the banked L1 dcache datapath.
- Latches the per-lane valid/we/address set.
- Each cycle, issues a bank-conflict-free subset of lanes to the bank array.
- Tracks per-lane completion and pulses done_o when every valid lane has been acknowledged.
- Sits between the VLSU request port and the dcache bank access / miss logic.

Parameters:
NUM_LANES, 8, number of vector lanes (power of 2, >=2)
NUM_BANKS, 8, number of word-interleaved data banks (power of 2, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_i  in  1  request valid; accepted when req_i && ready_o
lane_valid_i  in  NUM_LANES  lanes participating in request
lane_we_i  in  NUM_LANES  per-lane write enable
lane_addr_i  in  NUM_LANES*64  per-lane byte address; lane i at [i*64+:64]
ready_o  out  1  scheduler can accept a request
done_o  out  1  one-cycle pulse: all valid lanes of current request acknowledged
issue_valid_o  out  1  issue_mask_o is non-empty and offered to banks
issue_mask_o  out  NUM_LANES  lanes issued this cycle; at most one lane per bank
issue_we_o  out  NUM_LANES  latched we masked by issue_mask_o
issue_ready_i  in  1  bank array accepts the whole issue_mask_o this cycle
lane_ack_i  in  NUM_LANES  per-lane completion from bank/miss logic
busy_o  out  1  state != IDLE

Behaviour:
- Bank of lane i = lane_addr[i][3 +: log2(NUM_BANKS)], i.e. 8-byte word interleave.
- Bank indices are computed from the latched address copy.
- Registers:
  - pend[NUM_LANES]: not yet issued.
  - outst[NUM_LANES]: issued, awaiting ack.
  - we_q, addr_q: latched copies of the request.
- Reset (rst_i=1 at a clock edge, any state, including mid-request):
  - state=IDLE; pend=0, outst=0.
  - Outputs: ready_o=1, done_o=0, issue_valid_o=0, issue_mask_o=0, issue_we_o=0, busy_o=0.
  - In-flight lanes are dropped; acks arriving later are ignored.
- State IDLE:
  - ready_o=1.
  - On accept with lane_valid_i != 0: latch addr/we, pend <= lane_valid_i, go to ISSUE.
  - On accept with lane_valid_i == 0: stay IDLE, done_o=1 next cycle, no issue.
- State ISSUE:
  - ready_o=0.
  - Grant: for each bank b, the lowest-index pend lane mapping to b. issue_mask_o = OR of grants (combinational from pend/addr_q).
  - issue_valid_o = (issue_mask_o != 0), which is always true in ISSUE.
  - Cycle with issue_valid_o && issue_ready_i: pend <= pend & ~issue_mask_o; outst <= outst | issue_mask_o.
  - When the resulting pend == 0: go to DRAIN.
  - issue_ready_i=0: mask held stable, no state change.
- Ack handling (ISSUE and DRAIN):
  - outst <= outst & ~lane_ack_i.
  - Only lanes already in the outst register are cleared. An ack for a lane issued in the same cycle, not yet issued, invalid, or in IDLE is ignored.
  - Same-cycle issue and ack update both registers; new issues are ORed after the ack clear.
- State DRAIN:
  - ready_o=0, issue_valid_o=0.
  - When the next-state outst == 0: go to IDLE and register done_o=1 for one cycle.
- done_o is high in the first IDLE cycle, with ready_o=1 in that same cycle. A new request may be accepted in the done_o cycle.
- Latency:
  - Accept at edge T -> first issue_valid_o in cycle T+1.
  - All-distinct-bank request with issue_ready_i=1 and ack one cycle after issue -> done_o at T+3.
  - Worst case, all lanes in one bank: NUM_LANES issue cycles.
- No read/write coalescing. Same-word lanes are serialized like any bank conflict.
- issue_we_o = we_q & issue_mask_o.

Test Plan:
- Distinct banks: lane i addr=0x1000+8*i, valid=0xFF, issue_ready_i=1, ack all lanes the cycle after issue -> single issue with mask 0xFF, done_o pulses exactly once, 3 cycles after accept, then ready_o=1.
- Full conflict: lane i addr=0x1000+64*i (all bank 0), valid=0xFF -> 8 consecutive issues with masks 0x01,0x02,...,0x80; done_o only after ack of lane 7.
- Partial conflict: lanes 0,1 -> bank 2; lanes 2-7 distinct banks; valid=0xFF -> issue 0xFD then 0x02.
- Backpressure and stray acks:
  - Hold issue_ready_i=0 for 4 cycles with valid=0x0F -> issue_mask_o stable at 0x0F, pend unchanged, no done_o.
  - Acks for unissued lanes have no effect.
- Empty and back-to-back: req with valid=0x00 -> done_o next cycle, issue_valid_o never high; second req in the done_o cycle is accepted.
- Reset mid-op: assert rst_i during DRAIN with outst=0x0C -> next cycle ready_o=1, busy_o=0, done_o=0; a late lane_ack_i=0x0C produces no done_o.
